// File: rtl/swing_drive_scheduler.sv
// Pendulum coil sequencer: timestamps sensor rising edges, measures the swing period, fires a PULSE_US drive pulse at period>>PHASE_SHIFT.
// Latency: an edge acts 3 cycles after sensor_in rises, drive rises 1 cycle after the delay elapses; no backpressure, all strobes are single-cycle.
module swing_drive_scheduler #(
    parameter int unsigned PHASE_SHIFT   = 1,
    parameter int unsigned PULSE_US      = 2000,
    parameter int unsigned MIN_PERIOD_US = 100000,
    parameter int unsigned TIMEOUT_US    = 3000000
) (
    input  logic        CLK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] microseconds,
    input  logic        sensor_in,
    output logic        tb_clear_n,
    output logic        drive,
    output logic [31:0] period_us,
    output logic        period_valid,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD_US);
    localparam logic [31:0] PULSE_W = 32'(PULSE_US);
    localparam logic [31:0] TMO     = 32'(TIMEOUT_US);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MEASURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_FIRE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        s_meta, s_sync, s_prev;
    logic        sensor_edge;
    logic [31:0] last_ts, last_ts_d;
    logic [31:0] fire_ts, fire_ts_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] period_d;
    logic        period_valid_d, timeout_d, drive_d, clear_n_d;
    logic [31:0] elapsed, pulse_el;
    logic        accept, expired;

    assign sensor_edge = s_sync & ~s_prev;
    // Modular differences keep every comparison correct across the 2^32 wrap.
    assign elapsed     = microseconds - last_ts;
    assign pulse_el    = microseconds - fire_ts;
    assign accept      = sensor_edge && (elapsed >= MIN_P);
    assign expired     = elapsed >= TMO;
    assign state       = state_q;

    always_comb begin
        state_d        = state_q;
        last_ts_d      = last_ts;
        fire_ts_d      = fire_ts;
        delay_d        = delay_q;
        period_d       = period_us;
        period_valid_d = 1'b0;
        timeout_d      = 1'b0;
        drive_d        = drive;
        clear_n_d      = 1'b1;
        if (!enable) begin
            state_d   = ST_IDLE;
            drive_d   = 1'b0;
            clear_n_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drive_d = 1'b0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    drive_d = 1'b0;
                    if (sensor_edge) begin
                        last_ts_d = microseconds;
                        state_d   = ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_WAIT, ST_FIRE: begin
                    // Accepted edge outranks timeout, fire and pulse end; it truncates any pulse.
                    if (accept) begin
                        period_d       = elapsed;
                        period_valid_d = 1'b1;
                        last_ts_d      = microseconds;
                        delay_d        = elapsed >> PHASE_SHIFT;
                        drive_d        = 1'b0;
                        state_d        = ST_WAIT;
                    end else if (expired) begin
                        drive_d   = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                    end else if (state_q == ST_WAIT && elapsed >= delay_q) begin
                        drive_d   = 1'b1;
                        fire_ts_d = microseconds;
                        state_d   = ST_FIRE;
                    end else if (state_q == ST_FIRE && pulse_el >= PULSE_W) begin
                        drive_d = 1'b0;
                        state_d = ST_MEASURE;
                    end
                end
                default: begin
                    drive_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_meta       <= 1'b0;
            s_sync       <= 1'b0;
            s_prev       <= 1'b0;
            last_ts      <= '0;
            fire_ts      <= '0;
            delay_q      <= '0;
            period_us    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            drive        <= 1'b0;
            tb_clear_n   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_meta       <= sensor_in;
            s_sync       <= s_meta;
            s_prev       <= s_sync;
            last_ts      <= last_ts_d;
            fire_ts      <= fire_ts_d;
            delay_q      <= delay_d;
            period_us    <= period_d;
            period_valid <= period_valid_d;
            timeout      <= timeout_d;
            drive        <= drive_d;
            tb_clear_n   <= clear_n_d;
        end
    end

endmodule

// File: tb/tb_swing_drive_scheduler.sv
// Directed bench for swing_drive_scheduler with a clearable microsecond model and expectation queues.
// Latency and backpressure are not applicable; events are scored as the DUT emits them.
module tb_swing_drive_scheduler;

    localparam int US_DIV = 5;

    logic        CLK_50 = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] microseconds;
    logic        sensor_in;
    logic        tb_clear_n;
    logic        drive;
    logic [31:0] period_us;
    logic        period_valid;
    logic        timeout;
    logic [2:0]  state;

    int          div_cnt = 0;
    logic        preload = 1'b0;
    logic [31:0] preload_val = '0;
    int          total = 0;
    int          bad = 0;
    logic        drive_prev = 1'b0;

    logic [31:0] exp_period[$];
    logic [31:0] exp_rise[$];
    logic [31:0] exp_fall[$];
    logic [31:0] exp_tmo[$];

    always #10 CLK_50 = ~CLK_50;

    swing_drive_scheduler #(
        .PHASE_SHIFT  (1),
        .PULSE_US     (5),
        .MIN_PERIOD_US(10),
        .TIMEOUT_US   (1000)
    ) dut (
        .CLK_50      (CLK_50),
        .reset       (reset),
        .enable      (enable),
        .microseconds(microseconds),
        .sensor_in   (sensor_in),
        .tb_clear_n  (tb_clear_n),
        .drive       (drive),
        .period_us   (period_us),
        .period_valid(period_valid),
        .timeout     (timeout),
        .state       (state)
    );

    // Microsecond timebase: held at zero while cleared, optional preload.
    always @(posedge CLK_50) begin
        if (tb_clear_n !== 1'b1) begin
            microseconds <= '0;
            div_cnt      <= 0;
        end else if (preload) begin
            microseconds <= preload_val;
            div_cnt      <= 0;
        end else if (div_cnt == US_DIV - 1) begin
            microseconds <= microseconds + 32'd1;
            div_cnt      <= 0;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every DUT event must match the next queued expectation.
    always @(negedge CLK_50) begin
        if (period_valid === 1'b1) begin
            check("pv_expected", 32'(exp_period.size() != 0), 32'd1);
            if (exp_period.size() != 0) check("period_us", period_us, exp_period.pop_front());
        end
        if (timeout === 1'b1) begin
            check("timeout_expected", 32'(exp_tmo.size() != 0), 32'd1);
            if (exp_tmo.size() != 0) check("timeout_at_us", microseconds, exp_tmo.pop_front());
        end
        if (drive === 1'b1 && !drive_prev) begin
            check("rise_expected", 32'(exp_rise.size() != 0), 32'd1);
            if (exp_rise.size() != 0) check("drive_rise_us", microseconds, exp_rise.pop_front());
        end
        if (drive === 1'b0 && drive_prev) begin
            check("fall_expected", 32'(exp_fall.size() != 0), 32'd1);
            if (exp_fall.size() != 0) check("drive_fall_us", microseconds, exp_fall.pop_front());
        end
        drive_prev = (drive === 1'b1);
    end

    task automatic wait_us(input logic [31:0] t);
        int n;
        n = 0;
        while (microseconds !== t && n < 20000) begin
            @(negedge CLK_50);
            n++;
        end
        if (n >= 20000) begin
            total++;
            bad++;
            $error("FAIL wait_us: observed=%0h expected=%0h", microseconds, t);
        end
    endtask

    task automatic pulse_sensor();
        sensor_in = 1'b1;
        repeat (3) @(negedge CLK_50);
        sensor_in = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        @(negedge CLK_50);
        reset = 1'b0;
        repeat (2) @(negedge CLK_50);
    endtask

    function automatic logic [31:0] pending();
        return 32'(exp_period.size() + exp_rise.size() + exp_fall.size() + exp_tmo.size());
    endfunction

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        sensor_in = 1'b0;
        repeat (3) @(negedge CLK_50);
        check("rst_drive", 32'(drive), 32'd0);
        check("rst_clear_n", 32'(tb_clear_n), 32'd0);
        check("rst_period", period_us, 32'd0);
        check("rst_pv", 32'(period_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b0;
        @(negedge CLK_50);
        check("idle_clear_n", 32'(tb_clear_n), 32'd0);
        enable = 1'b1;
        @(negedge CLK_50);
        check("en_clear_n", 32'(tb_clear_n), 32'd1);
        check("en_state", 32'(state), 32'd1);

        // Basic period measurement and drive pulse.
        wait_us(100); pulse_sensor();
        exp_period.push_back(200); exp_rise.push_back(400); exp_fall.push_back(405);
        wait_us(300); pulse_sensor();
        wait_us(407);
        check("t1_state", 32'(state), 32'd2);
        check("t1_pending", pending(), 32'd0);

        // Debounce.
        restart();
        wait_us(100); pulse_sensor();
        wait_us(104); pulse_sensor();
        exp_period.push_back(200); exp_rise.push_back(400); exp_fall.push_back(405);
        wait_us(300); pulse_sensor();
        wait_us(407);
        check("t2_period", period_us, 32'd200);
        check("t2_pending", pending(), 32'd0);

        // Timeout after a single edge.
        restart();
        wait_us(100); pulse_sensor();
        exp_tmo.push_back(1100);
        wait_us(1102);
        check("t3_state", 32'(state), 32'd1);
        check("t3_drive", 32'(drive), 32'd0);
        check("t3_pending", pending(), 32'd0);

        // Edge during FIRE truncates the pulse.
        restart();
        exp_period.push_back(40); exp_rise.push_back(160);
        wait_us(100); pulse_sensor();
        wait_us(140); pulse_sensor();
        exp_fall.push_back(162); exp_period.push_back(22);
        exp_rise.push_back(173); exp_fall.push_back(178);
        wait_us(162); pulse_sensor();
        check("t4_state", 32'(state), 32'd3);
        check("t4_drive", 32'(drive), 32'd0);
        check("t4_period", period_us, 32'd22);
        wait_us(180);
        check("t4_pending", pending(), 32'd0);

        // Timebase wrap.
        restart();
        preload_val = 32'hFFFF_FF00;
        preload = 1'b1;
        @(negedge CLK_50);
        preload = 1'b0;
        exp_period.push_back(32'h200); exp_rise.push_back(32'h280); exp_fall.push_back(32'h285);
        wait_us(32'hFFFF_FF80); pulse_sensor();
        wait_us(32'h0000_0180); pulse_sensor();
        wait_us(32'h0000_0287);
        check("t5_period", period_us, 32'd512);
        check("t5_state", 32'(state), 32'd2);
        check("t5_pending", pending(), 32'd0);

        // Async reset mid-FIRE.
        restart();
        exp_period.push_back(200); exp_rise.push_back(400); exp_fall.push_back(0);
        wait_us(100); pulse_sensor();
        wait_us(300); pulse_sensor();
        wait_us(402);
        check("t6_drive_before", 32'(drive), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_drive", 32'(drive), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_clear_n", 32'(tb_clear_n), 32'd0);
        check("t6_rst_period", period_us, 32'd0);
        @(negedge CLK_50);
        reset = 1'b0;
        repeat (2) @(negedge CLK_50);

        // enable=0 mid-WAIT.
        exp_period.push_back(200);
        wait_us(100); pulse_sensor();
        wait_us(300); pulse_sensor();
        wait_us(350);
        check("t6_wait_state", 32'(state), 32'd3);
        enable = 1'b0;
        @(negedge CLK_50);
        check("t6_dis_drive", 32'(drive), 32'd0);
        check("t6_dis_state", 32'(state), 32'd0);
        check("t6_dis_clear_n", 32'(tb_clear_n), 32'd0);
        check("t6_dis_period", period_us, 32'd200);
        repeat (3) @(negedge CLK_50);
        check("t6_pending", pending(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
